// File: rtl/posit_weight_serializer_if.sv
// Parallel weight write port for posit_weight_serializer: valid/ready handshake
// carrying one right-aligned posit weight per accepted transfer.
interface posit_weight_serializer_if #(
  parameter int MAX_PREC = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [MAX_PREC-1:0] in_posit;

  modport master (output in_valid, output in_posit, input  in_ready);
  modport slave  (input  in_valid, input  in_posit, output in_ready);
endinterface

// File: rtl/posit_weight_serializer.sv
// Buffers parallel posit weights (es = 0) in a FIFO and streams them MSB-first, one bit per cycle.
// Optional feature macro POSIT_SER_STATS_EN adds saturating zero / NaR word counters.
module posit_weight_serializer #(
  parameter int MAX_PREC   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_set,
  input  logic [3:0]               cfg_precision,
  posit_weight_serializer_if.slave in_if,
  output logic                     w_out,
  output logic                     valid_out,
  output logic                     last_out,
  output logic                     set_out,
  output logic [3:0]               precision_out,
  output logic                     busy
`ifdef POSIT_SER_STATS_EN
  ,
  output logic [15:0]              zero_cnt,
  output logic [15:0]              nar_cnt
`endif
);

  localparam int CW = (MAX_PREC > 1) ? $clog2(MAX_PREC) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = PW + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t              state_q, state_d;
  logic [MAX_PREC-1:0] mem_q [FIFO_DEPTH];
  logic [MAX_PREC-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]       count_q, count_d;
  logic [MAX_PREC-1:0] shreg_q, shreg_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                w_out_q, w_out_d;
  logic                valid_out_q, valid_out_d;
  logic                last_out_q, last_out_d;
  logic                set_out_q, set_out_d;
  logic                busy_q, busy_d;
  logic                in_ready_q, in_ready_d;
  logic [3:0]          prec_q, prec_d;

  logic                push;
  logic                pop;
  logic [MAX_PREC-1:0] prec_mask;
  logic [MAX_PREC-1:0] head;
  logic [MAX_PREC-1:0] nar_word;
  logic [CW-1:0]       load_idx;
  logic [3:0]          cfg_clamped;

  // Precision-derived helpers: storage mask, MSB index and the NaR pattern
  always_comb begin
    prec_mask = '0;
    for (int i = 0; i < MAX_PREC; i++) begin
      prec_mask[i] = (i < int'(prec_q));
    end
    load_idx = CW'(prec_q - 4'd1);
    nar_word = {{(MAX_PREC-1){1'b0}}, 1'b1} << load_idx;
    head     = mem_q[rd_ptr_q];
    if (cfg_precision < 4'd2) begin
      cfg_clamped = 4'd2;
    end else if (cfg_precision > 4'(MAX_PREC)) begin
      cfg_clamped = 4'(MAX_PREC);
    end else begin
      cfg_clamped = cfg_precision;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    w_out_d     = w_out_q;
    valid_out_d = valid_out_q;
    last_out_d  = last_out_q;
    prec_d      = prec_q;
    set_out_d   = 1'b0;
    pop         = 1'b0;
    push        = in_if.in_valid && in_ready_q;

    // busy also covers a non-empty FIFO, so precision can never change under a queued word
    if (cfg_set && !busy_q) begin
      prec_d    = cfg_clamped;
      set_out_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == '0) begin
          if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d     = IDLE;
            valid_out_d = 1'b0;
            w_out_d     = 1'b0;
            last_out_d  = 1'b0;
          end
        end else begin
          bit_cnt_d  = bit_cnt_q - 1'b1;
          w_out_d    = shreg_q[bit_cnt_q - 1'b1];
          last_out_d = (bit_cnt_q == CW'(1));
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The popped word's MSB is registered on the pop edge itself, giving one-cycle latency
    if (pop) begin
      state_d     = SHIFT;
      shreg_d     = head;
      bit_cnt_d   = load_idx;
      w_out_d     = head[load_idx];
      valid_out_d = 1'b1;
      last_out_d  = 1'b0;
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = in_if.in_posit & prec_mask;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    count_d    = count_q + NW'(push) - NW'(pop);
    in_ready_d = (count_d != NW'(FIFO_DEPTH)) && !set_out_d;
    busy_d     = (count_d != '0) || (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      w_out_q     <= 1'b0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      set_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      prec_q      <= 4'(MAX_PREC);
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      w_out_q     <= w_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
      set_out_q   <= set_out_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      prec_q      <= prec_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign w_out          = w_out_q;
  assign valid_out      = valid_out_q;
  assign last_out       = last_out_q;
  assign set_out        = set_out_q;
  assign precision_out  = prec_q;
  assign busy           = busy_q;

`ifdef POSIT_SER_STATS_EN
  logic [15:0] zero_cnt_q, zero_cnt_d;
  logic [15:0] nar_cnt_q, nar_cnt_d;

  // Stored words are already masked to prec bits, so the head compares directly
  always_comb begin
    zero_cnt_d = zero_cnt_q;
    nar_cnt_d  = nar_cnt_q;
    if (set_out_d) begin
      zero_cnt_d = '0;
      nar_cnt_d  = '0;
    end else if (pop) begin
      if (head == '0 && zero_cnt_q != 16'hFFFF) begin
        zero_cnt_d = zero_cnt_q + 16'd1;
      end
      if (head == nar_word && nar_cnt_q != 16'hFFFF) begin
        nar_cnt_d = nar_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_cnt_q <= '0;
      nar_cnt_q  <= '0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
      nar_cnt_q  <= nar_cnt_d;
    end
  end

  assign zero_cnt = zero_cnt_q;
  assign nar_cnt  = nar_cnt_q;
`endif

endmodule

// File: tb/tb_posit_weight_serializer.sv
// Self-checking bench for posit_weight_serializer: scoreboard of expected serial bits
// filled on accepted pushes and drained as valid_out bits appear.
module tb_posit_weight_serializer;

  localparam int MAX_PREC   = 8;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_set;
  logic [3:0] cfg_precision;
  logic       w_out;
  logic       valid_out;
  logic       last_out;
  logic       set_out;
  logic [3:0] precision_out;
  logic       busy;
`ifdef POSIT_SER_STATS_EN
  logic [15:0] zero_cnt;
  logic [15:0] nar_cnt;
`endif

  posit_weight_serializer_if #(.MAX_PREC(MAX_PREC)) in_if ();

  posit_weight_serializer #(
    .MAX_PREC   (MAX_PREC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_set       (cfg_set),
    .cfg_precision (cfg_precision),
    .in_if         (in_if),
    .w_out         (w_out),
    .valid_out     (valid_out),
    .last_out      (last_out),
    .set_out       (set_out),
    .precision_out (precision_out),
    .busy          (busy)
`ifdef POSIT_SER_STATS_EN
    ,
    .zero_cnt      (zero_cnt),
    .nar_cnt       (nar_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_prec = 8;
  bit exp_bits[$];
  bit exp_last[$];

  // Reference model: a weight contributes its low cur_prec bits, MSB first
  task automatic sb_push(input logic [7:0] word);
    for (int i = cur_prec - 1; i >= 0; i--) begin
      exp_bits.push_back(word[i]);
      exp_last.push_back(i == 0);
    end
  endtask

  task automatic set_precision(input int p);
    @(negedge clk);
    cfg_set       = 1'b1;
    cfg_precision = 4'(p);
    @(negedge clk);
    cfg_set  = 1'b0;
    cur_prec = (p < 2) ? 2 : ((p > MAX_PREC) ? MAX_PREC : p);
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    cfg_set        = 1'b0;
    cfg_precision  = 4'd0;
    in_if.in_valid = 1'b0;
    in_if.in_posit = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (precision_out !== 4'd8) begin errors++; $display("[TB] FAIL reset_prec got %0d want 8", precision_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", valid_out); end
    checks++; if (set_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_set got %b want 0", set_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_if.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_in_rst got %b want 0", in_if.in_ready); end
    checks++; if (w_out !== 1'b0 || last_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_wlast got %b%b want 00", w_out, last_out); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_if.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_rst got %b want 1", in_if.in_ready); end
    cur_prec = 8;
  endtask

  task automatic test_precision_load();
    int p_in[3]  = '{1, 15, 5};
    int p_exp[3] = '{2, 8, 5};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cfg_set       = 1'b1;
      cfg_precision = 4'(p_in[k]);
      @(posedge clk);
      #1;
      checks++; if (set_out !== 1'b1) begin errors++; $display("[TB] FAIL cfg_pulse[%0d] got %b want 1", k, set_out); end
      checks++; if (precision_out !== 4'(p_exp[k])) begin errors++; $display("[TB] FAIL cfg_prec[%0d] got %0d want %0d", k, precision_out, p_exp[k]); end
      checks++; if (in_if.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL cfg_ready[%0d] got %b want 0", k, in_if.in_ready); end
      @(negedge clk);
      cfg_set = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (set_out !== 1'b0) begin errors++; $display("[TB] FAIL cfg_pulse_end[%0d] got %b want 0", k, set_out); end
      checks++; if (in_if.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL cfg_ready_end[%0d] got %b want 1", k, in_if.in_ready); end
      cur_prec = p_exp[k];
    end
  endtask

  task automatic test_single_word();
    bit eb, el;
    @(negedge clk);
    in_if.in_valid = 1'b1;
    in_if.in_posit = 8'hF6;
    checks++; if (in_if.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready got %b want 1", in_if.in_ready); end
    @(posedge clk);
    sb_push(8'hF6);
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL single_latency got %b want 0", valid_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_rise got %b want 1", busy); end
    @(negedge clk);
    in_if.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      eb = exp_bits.pop_front();
      el = exp_last.pop_front();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL single_valid[%0d] got %b want 1", k, valid_out); end
      checks++; if (w_out !== eb) begin errors++; $display("[TB] FAIL single_bit[%0d] got %b want %b", k, w_out, eb); end
      checks++; if (last_out !== el) begin errors++; $display("[TB] FAIL single_last[%0d] got %b want %b", k, last_out, el); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy[%0d] got %b want 1", k, busy); end
    end
    @(posedge clk);
    #1;
    checks++; if (valid_out !== 1'b0 || w_out !== 1'b0) begin errors++; $display("[TB] FAIL single_idle got v=%b w=%b want 0 0", valid_out, w_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_fall got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[2] = '{8'hFA, 8'h03};
    int  idx = 0;
    bit  started = 1'b0;
    bit  done = 1'b0;
    bit  acc, eb, el;
    set_precision(4);
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      in_if.in_valid = (idx < 2);
      in_if.in_posit = (idx < 2) ? words[idx] : 8'h00;
      acc = in_if.in_valid && in_if.in_ready;
      @(posedge clk);
      if (acc) begin sb_push(words[idx]); idx++; end
      #1;
      if (valid_out) begin
        started = 1'b1;
        checks++;
        if (exp_bits.size() == 0) begin errors++; $display("[TB] FAIL b2b_extra_bit got 1 want 0"); end
        else begin
          eb = exp_bits.pop_front();
          el = exp_last.pop_front();
          if (w_out !== eb || last_out !== el) begin errors++; $display("[TB] FAIL b2b_bit got w=%b l=%b want w=%b l=%b", w_out, last_out, eb, el); end
        end
      end else if (started) begin
        checks++;
        if (exp_bits.size() != 0) begin errors++; $display("[TB] FAIL b2b_gap got valid 0 want 1"); end
        else if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_fall got %b want 0", busy); end
        done = (exp_bits.size() == 0);
      end
    end
    in_if.in_valid = 1'b0;
    checks++; if (!done) begin errors++; $display("[TB] FAIL b2b_timeout got pending=%0d want 0", exp_bits.size()); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] words[8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hC3, 8'h3C, 8'hE7, 8'h7E};
    int  idx = 0;
    int  accepted = 0;
    bit  saw_full = 1'b0;
    bit  started = 1'b0;
    bit  done = 1'b0;
    bit  acc, eb, el;
    set_precision(8);
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      in_if.in_valid = (idx < 8);
      in_if.in_posit = (idx < 8) ? words[idx] : 8'h00;
      acc = in_if.in_valid && in_if.in_ready;
      if (in_if.in_valid && !in_if.in_ready) saw_full = 1'b1;
      @(posedge clk);
      if (acc) begin sb_push(words[idx]); accepted++; end
      if (idx < 8) idx++;
      #1;
      if (valid_out) begin
        started = 1'b1;
        checks++;
        if (exp_bits.size() == 0) begin errors++; $display("[TB] FAIL full_extra_bit got 1 want 0"); end
        else begin
          eb = exp_bits.pop_front();
          el = exp_last.pop_front();
          if (w_out !== eb || last_out !== el) begin errors++; $display("[TB] FAIL full_bit got w=%b l=%b want w=%b l=%b", w_out, last_out, eb, el); end
        end
      end else if (started) begin
        checks++;
        if (exp_bits.size() != 0) begin errors++; $display("[TB] FAIL full_gap got valid 0 want 1"); end
        else if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_fall got %b want 0", busy); end
        done = (exp_bits.size() == 0);
      end
    end
    in_if.in_valid = 1'b0;
    checks++; if (!done) begin errors++; $display("[TB] FAIL full_timeout got pending=%0d want 0", exp_bits.size()); end
    checks++; if (accepted != 5) begin errors++; $display("[TB] FAIL full_accepted got %0d want 5", accepted); end
    checks++; if (!saw_full) begin errors++; $display("[TB] FAIL full_ready_low got 0 want 1"); end
  endtask

  task automatic test_busy_cfg();
    int  idx = 0;
    bit  started = 1'b0;
    bit  done = 1'b0;
    bit  acc, eb, el;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      in_if.in_valid = (idx < 1);
      in_if.in_posit = 8'h5C;
      cfg_set        = (cyc == 2);
      cfg_precision  = 4'd3;
      acc = in_if.in_valid && in_if.in_ready;
      @(posedge clk);
      if (acc) begin sb_push(8'h5C); idx++; end
      #1;
      checks++; if (set_out !== 1'b0 || precision_out !== 4'd8) begin errors++; $display("[TB] FAIL busy_cfg got set=%b prec=%0d want set=0 prec=8", set_out, precision_out); end
      if (valid_out) begin
        started = 1'b1;
        checks++;
        if (exp_bits.size() == 0) begin errors++; $display("[TB] FAIL busy_extra_bit got 1 want 0"); end
        else begin
          eb = exp_bits.pop_front();
          el = exp_last.pop_front();
          if (w_out !== eb || last_out !== el) begin errors++; $display("[TB] FAIL busy_bit got w=%b l=%b want w=%b l=%b", w_out, last_out, eb, el); end
        end
      end else if (started) begin
        done = (exp_bits.size() == 0);
      end
    end
    in_if.in_valid = 1'b0;
    cfg_set        = 1'b0;
    checks++; if (!done) begin errors++; $display("[TB] FAIL busy_timeout got pending=%0d want 0", exp_bits.size()); end
  endtask

`ifdef POSIT_SER_STATS_EN
  task automatic test_stats();
    logic [7:0] words[3] = '{8'hF0, 8'h38, 8'h04};
    int  idx = 0;
    bit  started = 1'b0;
    bit  done = 1'b0;
    bit  acc, eb, el;
    set_precision(4);
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      in_if.in_valid = (idx < 3);
      in_if.in_posit = (idx < 3) ? words[idx] : 8'h00;
      acc = in_if.in_valid && in_if.in_ready;
      @(posedge clk);
      if (acc) begin sb_push(words[idx]); idx++; end
      #1;
      if (valid_out) begin
        started = 1'b1;
        checks++;
        if (exp_bits.size() == 0) begin errors++; $display("[TB] FAIL stats_extra_bit got 1 want 0"); end
        else begin
          eb = exp_bits.pop_front();
          el = exp_last.pop_front();
          if (w_out !== eb || last_out !== el) begin errors++; $display("[TB] FAIL stats_bit got w=%b l=%b want w=%b l=%b", w_out, last_out, eb, el); end
        end
      end else if (started) begin
        done = (exp_bits.size() == 0);
      end
    end
    in_if.in_valid = 1'b0;
    checks++; if (!done) begin errors++; $display("[TB] FAIL stats_timeout got pending=%0d want 0", exp_bits.size()); end
    checks++; if (zero_cnt !== 16'd1) begin errors++; $display("[TB] FAIL stats_zero got %0d want 1", zero_cnt); end
    checks++; if (nar_cnt !== 16'd1) begin errors++; $display("[TB] FAIL stats_nar got %0d want 1", nar_cnt); end
    set_precision(6);
    checks++; if (zero_cnt !== 16'd0 || nar_cnt !== 16'd0) begin errors++; $display("[TB] FAIL stats_clear got zero=%0d nar=%0d want 0 0", zero_cnt, nar_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_precision_load();
    test_single_word();
    test_back_to_back();
    test_fifo_full();
    test_busy_cfg();
`ifdef POSIT_SER_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
